// File: rtl/rx_hdr_block_lock_if.sv
// SERDES header-path bundle for the 64b/66b block-lock FSM.
// The SERDES/stimulus side uses the master modport; the lock FSM uses the slave modport.
interface rx_hdr_block_lock_if #(
  parameter int HDR_WIDTH  = 2,
  parameter int STAT_WIDTH = 17
);
  logic [HDR_WIDTH-1:0]  serdes_rx_hdr;
  logic                  serdes_rx_bitslip;
  logic                  rx_block_lock;
  logic [4:0]            rx_sh_invalid_cnt;
  logic [STAT_WIDTH-1:0] stat_hdr_to_lock;
  logic [STAT_WIDTH-1:0] stat_slip_cnt;
  logic [STAT_WIDTH-1:0] stat_lock_loss_cnt;

  modport master (
    output serdes_rx_hdr,
    input  serdes_rx_bitslip, rx_block_lock, rx_sh_invalid_cnt,
    input  stat_hdr_to_lock, stat_slip_cnt, stat_lock_loss_cnt
  );

  modport slave (
    input  serdes_rx_hdr,
    output serdes_rx_bitslip, rx_block_lock, rx_sh_invalid_cnt,
    output stat_hdr_to_lock, stat_slip_cnt, stat_lock_loss_cnt
  );
endinterface

// File: rtl/rx_hdr_block_lock.sv
// 64b/66b receive block-lock FSM: classifies sync headers, requests bitslips, asserts block lock.
// Optional statistics counters are built when RX_HDR_LOCK_STATS_EN is defined; otherwise stat_* tie to 0.
module rx_hdr_block_lock #(
  parameter int HDR_WIDTH           = 2,
  parameter int SH_WINDOW           = 64,
  parameter int INVALID_MAX         = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int STAT_WIDTH          = 17
) (
  input  logic                rx_clk_tb,
  input  logic                rx_rst_tb,
  rx_hdr_block_lock_if.slave  rx_if
);

  localparam int CNT_W   = $clog2(SH_WINDOW) + 1;
  localparam int TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                           BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] L_WIN     = CNT_W'(SH_WINDOW);
  localparam logic [4:0]       L_INV_MAX = 5'(INVALID_MAX);
  localparam logic [TMR_W-1:0] L_HIGH_LD = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] L_LOW_LD  = TMR_W'(BITSLIP_LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_COUNT,
    ST_SLIP_HIGH,
    ST_SLIP_WAIT
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_sh_cnt;
  logic [4:0]       r_inv_cnt;
  logic [TMR_W-1:0] r_tmr;
  logic             r_bitslip;
  logic             r_lock;

  logic             w_hdr_inv;
  logic             w_in_count;
  logic [CNT_W-1:0] w_sh_cnt_inc;
  logic [4:0]       w_inv_cnt_inc;
  logic             w_win_end;
  logic             w_lose;
  logic             w_slip;
  logic             w_gain;

  // 01/10 are the only legal sync headers; 00 and 11 are invalid.
  assign w_hdr_inv     = (rx_if.serdes_rx_hdr == {HDR_WIDTH{1'b0}}) ||
                         (rx_if.serdes_rx_hdr == {HDR_WIDTH{1'b1}});
  assign w_in_count    = (r_state == ST_COUNT);
  assign w_sh_cnt_inc  = r_sh_cnt + 1'b1;
  assign w_inv_cnt_inc = r_inv_cnt + {4'b0000, w_hdr_inv};
  assign w_win_end     = w_in_count && (w_sh_cnt_inc == L_WIN);
  // Lock loss is checked before window end, so it wins when both land on one header.
  assign w_lose        = w_in_count && r_lock && (w_inv_cnt_inc == L_INV_MAX);
  assign w_slip        = w_lose || (w_in_count && !r_lock && w_hdr_inv);
  assign w_gain        = w_win_end && !r_lock && !w_slip;

  always_ff @(posedge rx_clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      r_state   <= ST_COUNT;
      r_sh_cnt  <= '0;
      r_inv_cnt <= '0;
      r_tmr     <= '0;
      r_bitslip <= 1'b0;
      r_lock    <= 1'b0;
    end else begin
      case (r_state)
        ST_COUNT: begin
          if (w_slip) begin
            r_state   <= ST_SLIP_HIGH;
            r_bitslip <= 1'b1;
            r_lock    <= 1'b0;
            r_tmr     <= L_HIGH_LD;
            r_sh_cnt  <= '0;
            r_inv_cnt <= '0;
          end else if (w_win_end) begin
            r_sh_cnt  <= '0;
            r_inv_cnt <= '0;
            if (w_gain) r_lock <= 1'b1;
          end else begin
            r_sh_cnt  <= w_sh_cnt_inc;
            r_inv_cnt <= w_inv_cnt_inc;
          end
        end
        ST_SLIP_HIGH: begin
          if (r_tmr == '0) begin
            r_bitslip <= 1'b0;
            if (BITSLIP_LOW_CYCLES == 0) begin
              r_state <= ST_COUNT;
            end else begin
              r_state <= ST_SLIP_WAIT;
              r_tmr   <= L_LOW_LD;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        ST_SLIP_WAIT: begin
          // Header sampled on the exit edge is still discarded.
          if (r_tmr == '0) r_state <= ST_COUNT;
          else             r_tmr   <= r_tmr - 1'b1;
        end
        default: r_state <= ST_COUNT;
      endcase
    end
  end

  assign rx_if.serdes_rx_bitslip = r_bitslip;
  assign rx_if.rx_block_lock     = r_lock;
  assign rx_if.rx_sh_invalid_cnt = r_inv_cnt;

`ifdef RX_HDR_LOCK_STATS_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STAT_WIDTH-1:0] r_hdr_to_lock;
  logic [STAT_WIDTH-1:0] r_slip_cnt;
  logic [STAT_WIDTH-1:0] r_loss_cnt;

  // hdr_to_lock runs while unlocked (slip cycles included) and freezes once lock is taken.
  always_ff @(posedge rx_clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      r_hdr_to_lock <= '0;
      r_slip_cnt    <= '0;
      r_loss_cnt    <= '0;
    end else begin
      if (w_slip) r_slip_cnt <= sat_inc(r_slip_cnt);
      if (w_lose) r_loss_cnt <= sat_inc(r_loss_cnt);
      if (w_lose)       r_hdr_to_lock <= '0;
      else if (!r_lock) r_hdr_to_lock <= sat_inc(r_hdr_to_lock);
    end
  end

  assign rx_if.stat_hdr_to_lock   = r_hdr_to_lock;
  assign rx_if.stat_slip_cnt      = r_slip_cnt;
  assign rx_if.stat_lock_loss_cnt = r_loss_cnt;
`else
  assign rx_if.stat_hdr_to_lock   = {STAT_WIDTH{1'b0}};
  assign rx_if.stat_slip_cnt      = {STAT_WIDTH{1'b0}};
  assign rx_if.stat_lock_loss_cnt = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rx_hdr_block_lock.sv
// Directed bench for rx_hdr_block_lock: lock acquisition, slip timing, lock loss, async reset, stats.
module tb_rx_hdr_block_lock;

`ifdef RX_HDR_LOCK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic rx_clk_tb = 1'b0;
  logic rx_rst_tb = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_slip_seen;
  int   n_lock_seen;
  int   n_inv_seen;

  rx_hdr_block_lock_if #(.HDR_WIDTH(2), .STAT_WIDTH(17)) bus ();

  rx_hdr_block_lock #(
    .HDR_WIDTH(2), .SH_WINDOW(64), .INVALID_MAX(16),
    .BITSLIP_HIGH_CYCLES(1), .BITSLIP_LOW_CYCLES(8), .STAT_WIDTH(17)
  ) dut (
    .rx_clk_tb(rx_clk_tb),
    .rx_rst_tb(rx_rst_tb),
    .rx_if(bus)
  );

  always #5 rx_clk_tb = ~rx_clk_tb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] st(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] h);
    bus.serdes_rx_hdr = h;
    @(posedge rx_clk_tb);
    #1;
  endtask

  task automatic run_n(input logic [1:0] h, input int n);
    for (int i = 0; i < n; i++) begin
      step(h);
      if (bus.serdes_rx_bitslip) n_slip_seen++;
      if (bus.rx_block_lock)     n_lock_seen++;
      if (bus.rx_sh_invalid_cnt != 5'd0) n_inv_seen++;
    end
  endtask

  task automatic clr_seen();
    n_slip_seen = 0;
    n_lock_seen = 0;
    n_inv_seen  = 0;
  endtask

  task automatic chk_stats(input string tag, input int h2l, input int slips, input int loss);
    chk({tag, "_h2l"},  32'(bus.stat_hdr_to_lock),   st(h2l));
    chk({tag, "_slip"}, 32'(bus.stat_slip_cnt),      st(slips));
    chk({tag, "_loss"}, 32'(bus.stat_lock_loss_cnt), st(loss));
  endtask

  task automatic do_reset();
    rx_rst_tb = 1'b1;
    @(posedge rx_clk_tb);
    @(posedge rx_clk_tb);
    #2 rx_rst_tb = 1'b0;
  endtask

  initial begin
    bus.serdes_rx_hdr = 2'b10;
    #1 rx_rst_tb = 1'b1;
    #2;
    chk("rst_lock",    32'(bus.rx_block_lock),     0);
    chk("rst_bitslip", 32'(bus.serdes_rx_bitslip), 0);
    chk("rst_inv",     32'(bus.rx_sh_invalid_cnt), 0);
    chk_stats("rst", 0, 0, 0);
    @(posedge rx_clk_tb);
    #2 rx_rst_tb = 1'b0;

    // 1: 64 clean headers give lock exactly after the 64th
    clr_seen();
    run_n(2'b10, 63);
    chk("t1_lock_63", 32'(bus.rx_block_lock), 0);
    step(2'b10);
    chk("t1_lock_64", 32'(bus.rx_block_lock), 1);
    chk("t1_noslip",  32'(n_slip_seen), 0);
    chk_stats("t1", 64, 0, 0);

    // 3: 15 invalid in a window keeps lock; 16 in the next window drops it
    run_n(2'b11, 15);
    chk("t3_inv15",   32'(bus.rx_sh_invalid_cnt), 15);
    chk("t3_lock15",  32'(bus.rx_block_lock), 1);
    run_n(2'b10, 49);
    chk("t3_winclr",  32'(bus.rx_sh_invalid_cnt), 0);
    chk("t3_lockwin", 32'(bus.rx_block_lock), 1);
    run_n(2'b11, 15);
    chk("t3_lock_b15", 32'(bus.rx_block_lock), 1);
    step(2'b11);
    chk("t3_lost",    32'(bus.rx_block_lock), 0);
    chk("t3_slip_hi", 32'(bus.serdes_rx_bitslip), 1);
    chk("t3_invclr",  32'(bus.rx_sh_invalid_cnt), 0);
    chk_stats("t3", 0, 1, 1);
    step(2'b11);
    chk("t3_slip_lo", 32'(bus.serdes_rx_bitslip), 0);
    clr_seen();
    run_n(2'b11, 8);
    chk("t3_wait_noslip", 32'(n_slip_seen), 0);
    chk("t3_wait_noinv",  32'(n_inv_seen), 0);
    run_n(2'b01, 63);
    chk("t3_relock63", 32'(bus.rx_block_lock), 0);
    step(2'b01);
    chk("t3_relock64", 32'(bus.rx_block_lock), 1);
    chk_stats("t3r", 73, 1, 1);

    // 4: 16th invalid lands on the 64th header of the window
    run_n(2'b10, 48);
    run_n(2'b00, 15);
    chk("t4_lock63", 32'(bus.rx_block_lock), 1);
    chk("t4_inv63",  32'(bus.rx_sh_invalid_cnt), 15);
    step(2'b00);
    chk("t4_lost",   32'(bus.rx_block_lock), 0);
    chk("t4_slip",   32'(bus.serdes_rx_bitslip), 1);
    chk_stats("t4", 0, 2, 2);

    // 5: async reset while bitslip is high
    #1 rx_rst_tb = 1'b1;
    #1;
    chk("t5_bitslip", 32'(bus.serdes_rx_bitslip), 0);
    chk("t5_lock",    32'(bus.rx_block_lock), 0);
    chk_stats("t5", 0, 0, 0);
    @(posedge rx_clk_tb);
    #2 rx_rst_tb = 1'b0;

    // 2: invalid 64th header forces a slip, then 8 ignored headers, then relock
    clr_seen();
    run_n(2'b10, 63);
    step(2'b11);
    chk("t2_slip_hi", 32'(bus.serdes_rx_bitslip), 1);
    chk("t2_nolock",  32'(bus.rx_block_lock), 0);
    chk("t2_prelock", 32'(n_lock_seen), 0);
    step(2'b11);
    chk("t2_slip_lo", 32'(bus.serdes_rx_bitslip), 0);
    clr_seen();
    run_n(2'b11, 8);
    chk("t2_wait_noslip", 32'(n_slip_seen), 0);
    chk("t2_wait_nolock", 32'(n_lock_seen), 0);
    run_n(2'b01, 63);
    chk("t2_lock63", 32'(bus.rx_block_lock), 0);
    step(2'b01);
    chk("t2_lock64", 32'(bus.rx_block_lock), 1);
    chk_stats("t2", 137, 1, 0);

    // async reset while locked drops lock without a clock edge
    #1 rx_rst_tb = 1'b1;
    #1;
    chk("t5b_lock", 32'(bus.rx_block_lock), 0);
    @(posedge rx_clk_tb);
    #2 rx_rst_tb = 1'b0;

    // 6: one invalid at header 10, then clean
    clr_seen();
    run_n(2'b10, 9);
    step(2'b00);
    chk("t6_slip_hi", 32'(bus.serdes_rx_bitslip), 1);
    run_n(2'b10, 9);
    run_n(2'b10, 63);
    chk("t6_lock82", 32'(bus.rx_block_lock), 0);
    step(2'b10);
    chk("t6_lock83", 32'(bus.rx_block_lock), 1);
    chk_stats("t6", 83, 1, 0);

    do_reset();
    chk("end_rst_lock", 32'(bus.rx_block_lock), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
